// File: rtl/gcd_mm_engine.sv
// gcd_mm_engine -- Avalon-MM slave computing gcd(OPA, OPB) with the binary
// (Stein) algorithm. A write to OPB launches a computation. The bus is always
// 32 bits wide; operands and result are WIDTH bits and read back zero-extended.
//
// Optional feature macro: GCD_IRQ_EN (adds the CTRL.irq_en bit and the irq port).
//
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset
//   chipselect  slave select; read/write are ignored when low
//   address     word address (0 OPA, 1 OPB, 2 RESULT, 3 STATUS, 4 CTRL, 5 CYCLES)
//   read        read strobe; readdata is valid the following cycle
//   write       write strobe
//   byteenable  per-byte write lane enables
//   writedata   write data
//   readdata    registered read data
//   irq         level interrupt = done & irq_en (GCD_IRQ_EN builds only)
module gcd_mm_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
`ifdef GCD_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ALIGN, S_REDUCE, S_FINISH} state_t;
  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_opa, r_opb, r_result, r_a, r_b;
  logic [KW-1:0]    r_k;
  logic [CNT_W-1:0] r_cycles, w_cyc_inc;
  logic             r_done, r_busy, r_err, r_ovr, w_done_nxt;
  logic [31:0]      r_readdata, w_rdata;
  logic             w_wr, w_rd, w_wr_opa, w_wr_opb, w_wr_stat, w_launch, w_drop, w_zero;
  logic [WIDTH-1:0] w_opa_new, w_opb_new;

  // Merge a 32-bit write into a WIDTH-bit register lane by lane; bits above
  // WIDTH fall away on the final truncation.
  function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0] be);
    logic [31:0] v;
    v = 32'(cur);
    for (int i = 0; i < 4; i++)
      if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
    return v[WIDTH-1:0];
  endfunction

  assign w_wr      = chipselect & write;
  assign w_rd      = chipselect & read;
  assign w_wr_opa  = w_wr && (address == 3'd0);
  assign w_wr_opb  = w_wr && (address == 3'd1);
  assign w_wr_stat = w_wr && (address == 3'd3) && byteenable[0];
  // busy is high exactly while the FSM is outside IDLE, so a launch can only
  // be accepted from IDLE and a write in the FINISH cycle is dropped.
  assign w_launch  = w_wr_opb & ~r_busy;
  assign w_drop    = (w_wr_opa | w_wr_opb) & r_busy;
  assign w_zero    = (r_opa == '0) || (r_opb == '0);
  assign w_cyc_inc = (r_cycles == '1) ? r_cycles : r_cycles + CNT_W'(1);
  assign w_opa_new = f_merge(r_opa, writedata, byteenable);
  assign w_opb_new = f_merge(r_opb, writedata, byteenable);

  // FINISH setting done takes priority over a same-cycle STATUS clear.
  always_comb begin
    w_done_nxt = r_done;
    if (w_launch || (w_wr_stat && writedata[0])) w_done_nxt = 1'b0;
    if (r_state == S_FINISH)                     w_done_nxt = 1'b1;
  end

`ifdef GCD_IRQ_EN
  logic r_irq_en, r_irq, w_irq_en_nxt;
  assign w_irq_en_nxt = (w_wr && (address == 3'd4) && byteenable[0]) ? writedata[0] : r_irq_en;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      // Built from next-state values so irq rises and falls with done/irq_en.
      r_irq    <= w_done_nxt & w_irq_en_nxt;
    end
  end
  assign irq = r_irq;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_launch) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = w_zero ? S_FINISH : S_ALIGN;
      S_ALIGN:  if (r_a[0] | r_b[0]) w_state_nxt = S_REDUCE;
      S_REDUCE: if (r_a[0] && r_b[0] && (r_a == r_b)) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opa <= '0; r_opb <= '0; r_result <= '0; r_a <= '0; r_b <= '0; r_k <= '0;
      r_cycles <= '0; r_done <= 1'b0; r_busy <= 1'b0; r_err <= 1'b0; r_ovr <= 1'b0;
    end else begin
      if (w_wr_opa && !r_busy) r_opa <= w_opa_new;
      if (w_launch)            r_opb <= w_opb_new;
      if (w_drop)                              r_ovr <= 1'b1;
      else if (w_wr_stat && writedata[3])      r_ovr <= 1'b0;
      if (w_wr_stat && writedata[2])           r_err <= 1'b0;
      r_done <= w_done_nxt;
      if (w_launch) begin
        r_busy <= 1'b1;
        r_err  <= 1'b0;
      end
      case (r_state)
        S_LOAD: begin
          r_a      <= r_opa;
          r_b      <= r_opb;
          r_k      <= '0;
          r_cycles <= '0;
          if (w_zero) begin
            // Zero operand: the answer is the other operand. Keeping it in a
            // with k=0 makes the FINISH rewrite of RESULT a no-op.
            r_a      <= r_opa | r_opb;
            r_result <= r_opa | r_opb;
            if ((r_opa == '0) && (r_opb == '0)) r_err <= 1'b1;
          end
        end
        S_ALIGN: begin
          r_cycles <= w_cyc_inc;
          if (!r_a[0] && !r_b[0]) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + KW'(1);
          end
        end
        S_REDUCE: begin
          r_cycles <= w_cyc_inc;
          if (!r_a[0])            r_a <= r_a >> 1;
          else if (!r_b[0])       r_b <= r_b >> 1;
          else if (r_a == r_b)    r_a <= r_a;
          else if (r_a > r_b)     r_a <= r_a - r_b;
          else                    r_b <= r_b - r_a;
        end
        S_FINISH: begin
          r_result <= r_a << r_k;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      3'd0: w_rdata = 32'(r_opa);
      3'd1: w_rdata = 32'(r_opb);
      3'd2: w_rdata = 32'(r_result);
      3'd3: w_rdata = {28'd0, r_ovr, r_err, r_busy, r_done};
`ifdef GCD_IRQ_EN
      3'd4: w_rdata = {31'd0, r_irq_en};
`endif
      3'd5: w_rdata = 32'(r_cycles);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_readdata <= '0;
    else if (w_rd) r_readdata <= w_rdata;
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_gcd_mm_engine.sv
// Scoreboard bench for gcd_mm_engine: reads push hand-computed expectations,
// a negedge monitor pops and compares when readdata becomes valid.
module tb_gcd_mm_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs32 = 1'b0, cs16 = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] rdata32, rdata16;
`ifdef GCD_IRQ_EN
  logic        irq32, irq16;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] q32_e[$], q16_e[$];
  string       q32_n[$], q16_n[$];
  logic        rv32 = 1'b0, rv16 = 1'b0;

  localparam logic [2:0] A_OPA = 3'd0, A_OPB = 3'd1, A_RES = 3'd2, A_STAT = 3'd3,
                         A_CTRL = 3'd4, A_CYC = 3'd5;

  always #5 clk = ~clk;

  gcd_mm_engine #(.WIDTH(32), .CNT_W(16)) u_dut32 (
    .clk(clk), .rst(rst), .chipselect(cs32), .address(address), .read(read),
    .write(write), .byteenable(byteenable), .writedata(writedata), .readdata(rdata32)
`ifdef GCD_IRQ_EN
    , .irq(irq32)
`endif
  );

  gcd_mm_engine #(.WIDTH(16), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .chipselect(cs16), .address(address), .read(read),
    .write(write), .byteenable(byteenable), .writedata(writedata), .readdata(rdata16)
`ifdef GCD_IRQ_EN
    , .irq(irq16)
`endif
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  // Monitor: a read sampled at a posedge presents readdata by the next negedge.
  always @(posedge clk) begin
    rv32 <= cs32 & read;
    rv16 <= cs16 & read;
  end

  always @(negedge clk) begin
    if (rv32) begin
      if (q32_e.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb32_underflow: got 0x%08h expected none", rdata32);
      end else chk(q32_n.pop_front(), rdata32, q32_e.pop_front());
    end
    if (rv16) begin
      if (q16_e.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb16_underflow: got 0x%08h expected none", rdata16);
      end else chk(q16_n.pop_front(), rdata16, q16_e.pop_front());
    end
  end

  task automatic wr(input logic s16, input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    cs32 = !s16; cs16 = s16; write = 1'b1; address = a; writedata = d; byteenable = be;
    @(posedge clk); #1;
    cs32 = 1'b0; cs16 = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic s16, input logic [2:0] a, input logic [31:0] e,
                    input string n);
    cs32 = !s16; cs16 = s16; read = 1'b1; address = a;
    if (s16) begin q16_e.push_back(e); q16_n.push_back(n); end
    else     begin q32_e.push_back(e); q32_n.push_back(n); end
    @(posedge clk); #1;
    cs32 = 1'b0; cs16 = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #23;
    chk("rst_rdata", rdata32, 32'h0);
`ifdef GCD_IRQ_EN
    chk("rst_irq", {31'd0, irq32}, 32'h0);
`endif
    @(posedge clk); #1 rst = 1'b1;
    idle(1);
    rd(0, A_STAT, 32'h0, "rst_status");
    rd(0, A_RES,  32'h0, "rst_result");
    rd(0, A_CYC,  32'h0, "rst_cycles");

    // 91,21: busy for 10 cycles, gcd 7, 8 iteration cycles
    wr(0, A_OPA, 91, 4'hF);
    wr(0, A_OPB, 21, 4'hF);
    for (int i = 1; i <= 10; i++) rd(0, A_STAT, 32'h2, $sformatf("busy91_c%0d", i));
    rd(0, A_STAT, 32'h1, "done91");
    rd(0, A_RES,  7,     "res91");
    rd(0, A_CYC,  8,     "cyc91");

    // 12,18: two ALIGN + four REDUCE
    wr(0, A_OPA, 12, 4'hF);
    wr(0, A_OPB, 18, 4'hF);
    idle(12);
    rd(0, A_RES,  6,     "res12_18");
    rd(0, A_CYC,  6,     "cyc12_18");
    rd(0, A_STAT, 32'h1, "stat12_18");

    // 0,5: exactly two cycles
    wr(0, A_OPA, 0, 4'hF);
    wr(0, A_OPB, 5, 4'hF);
    rd(0, A_STAT, 32'h2, "zero_busy1");
    rd(0, A_STAT, 32'h2, "zero_busy2");
    rd(0, A_STAT, 32'h1, "zero_done");
    rd(0, A_RES,  5,     "zero_res");
    rd(0, A_CYC,  0,     "zero_cyc");

    // 0,0: err
    wr(0, A_OPB, 0, 4'hF);
    idle(4);
    rd(0, A_STAT, 32'h5, "zz_stat");
    rd(0, A_RES,  0,     "zz_res");
    wr(0, A_STAT, 32'h4, 4'h1);
    rd(0, A_STAT, 32'h1, "err_clear");

    // 2,1023 with a dropped OPA write while busy
    wr(0, A_OPA, 2, 4'hF);
    wr(0, A_OPB, 1023, 4'hF);
    wr(0, A_OPA, 9, 4'hF);
    idle(60);
    rd(0, A_OPA,  2,     "ovr_opa_kept");
    rd(0, A_STAT, 32'h9, "ovr_stat");
    rd(0, A_RES,  1,     "res2_1023");
    rd(0, A_CYC,  21,    "cyc2_1023");
    wr(0, A_STAT, 32'h8, 4'h1);
    rd(0, A_STAT, 32'h1, "ovr_clear");

    // byte lanes
    wr(0, A_OPA, 32'h0, 4'hF);
    wr(0, A_OPA, 32'hFFFF_FFFF, 4'b0001);
    rd(0, A_OPA, 32'h0000_00FF, "be_lane0");
    wr(0, A_OPA, 32'h00AB_0000, 4'b0100);
    rd(0, A_OPA, 32'h00AB_00FF, "be_lane2");

    // unmapped / read-only / CTRL
    rd(0, 3'd6, 0, "addr6");
    rd(0, 3'd7, 0, "addr7");
    wr(0, A_RES, 32'h55, 4'hF);
    rd(0, A_RES, 1, "res_ro");
    wr(0, A_CYC, 32'h55, 4'hF);
    rd(0, A_CYC, 21, "cyc_ro");
    wr(0, A_CTRL, 32'h1, 4'hF);
`ifdef GCD_IRQ_EN
    rd(0, A_CTRL, 1, "ctrl_rw");
`else
    rd(0, A_CTRL, 0, "ctrl_absent");
`endif

    // WIDTH=16 instance: upper bits dropped, gcd(0x5678,0x24)=4
    wr(1, A_OPA, 32'h1234_5678, 4'hF);
    rd(1, A_OPA, 32'h0000_5678, "w16_opa");
    wr(1, A_OPB, 32'hFFFF_0024, 4'hF);
    idle(100);
    rd(1, A_OPB,  32'h24, "w16_opb");
    rd(1, A_RES,  4,      "w16_res");
    rd(1, A_STAT, 32'h1,  "w16_stat");

`ifdef GCD_IRQ_EN
    // irq follows done & irq_en (irq_en already 1)
    wr(0, A_OPA, 1, 4'hF);
    wr(0, A_OPB, 1, 4'hF);
    idle(3);
    chk("irq_low_busy", {31'd0, irq32}, 32'h0);
    idle(1);
    chk("irq_rise", {31'd0, irq32}, 32'h1);
    wr(0, A_STAT, 32'h1, 4'h1);
    chk("irq_clr_done", {31'd0, irq32}, 32'h0);
    wr(0, A_CTRL, 32'h0, 4'hF);
    wr(0, A_OPB, 1, 4'hF);
    idle(6);
    chk("irq_masked", {31'd0, irq32}, 32'h0);
    wr(0, A_CTRL, 32'h1, 4'hF);
    chk("irq_unmask", {31'd0, irq32}, 32'h1);
`endif

    // reset mid-computation
    wr(0, A_OPA, 91, 4'hF);
    wr(0, A_OPB, 21, 4'hF);
    rd(0, A_OPA, 91, "pre_rst_opa");
    idle(2);
    rst = 1'b0;
    #1;
    chk("midrst_rdata", rdata32, 32'h0);
`ifdef GCD_IRQ_EN
    chk("midrst_irq", {31'd0, irq32}, 32'h0);
`endif
    @(posedge clk); #1 rst = 1'b1;
    idle(1);
    rd(0, A_STAT, 0, "midrst_stat");
    rd(0, A_RES,  0, "midrst_res");
    rd(0, A_OPA,  0, "midrst_opa");
    rd(0, A_CYC,  0, "midrst_cyc");
    idle(3);

    chk("sb32_drain", 32'(q32_e.size()), 32'h0);
    chk("sb16_drain", 32'(q16_e.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

endmodule
